// File: rtl/iter_div_pkg.sv
// Shared EXU divider definitions: FSM states, nominal latency and op encoding.
package iter_div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_LAT   = DIV_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Op encoding shared with the decoder: DIV.W/DIV.WU/MOD.W/MOD.WU
  typedef struct packed {
    logic op_rem;
    logic op_signed;
  } div_op_t;

endpackage

// File: rtl/iter_div_if.sv
// Request/response bundle between the EXU issue logic (master) and the divider (slave).
interface iter_div_if
  import iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic             op_signed;
  logic             op_rem;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output in_valid, op_signed, op_rem, dividend, divisor, out_ready,
    input  in_ready, out_valid, result, div_by_zero
  );

  modport slave (
    input  in_valid, op_signed, op_rem, dividend, divisor, out_ready,
    output in_ready, out_valid, result, div_by_zero
  );
endinterface

// File: rtl/iter_div_lzc.sv
// Parameterised leading-zero counter; an all-zero input returns WIDTH.
module iter_div_lzc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]             val_i,
  output logic [$clog2(WIDTH+1)-1:0]   count_c_o
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  // Highest set bit wins because it is visited last
  always_comb begin
    count_c_o = CW'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (val_i[i]) count_c_o = CW'(int'(WIDTH) - 1 - i);
    end
  end
endmodule

// File: rtl/iter_div.sv
// Radix-2 non-restoring iterative divider for DIV/MOD (signed and unsigned).
// Optional DIV_SKIP_ZERO_EN skips the dividend's leading-zero steps.
module iter_div
  import iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  iter_div_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  div_state_e       state_q;
  div_op_t          op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             dvd_neg_q;
  logic             dvs_neg_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             dbz_q;

  logic             dvd_neg_c;
  logic             dvs_neg_c;
  logic [WIDTH-1:0] dvd_mag_c;
  logic [WIDTH-1:0] dvs_mag_c;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] rem_mag_c;
  logic [WIDTH-1:0] quo_res_c;
  logic [WIDTH-1:0] rem_res_c;

  // Operand magnitudes; unsigned ops pass the raw values through
  always_comb begin
    dvd_neg_c = bus.op_signed & bus.dividend[WIDTH-1];
    dvs_neg_c = bus.op_signed & bus.divisor[WIDTH-1];
    dvd_mag_c = dvd_neg_c ? -bus.dividend : bus.dividend;
    dvs_mag_c = dvs_neg_c ? -bus.divisor  : bus.divisor;
  end

  // One non-restoring step; the extra remainder bit keeps unsigned 0xFFFF_FFFF divisors exact
  always_comb begin
    rem_sh_c = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    rem_d    = rem_q[WIDTH] ? rem_sh_c + {1'b0, dvs_q} : rem_sh_c - {1'b0, dvs_q};
  end

  // Final correction and sign application; INT_MIN / -1 wraps naturally
  always_comb begin
    rem_mag_c = rem_q[WIDTH] ? rem_q[WIDTH-1:0] + dvs_q : rem_q[WIDTH-1:0];
    quo_res_c = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
    rem_res_c = dvd_neg_q ? -rem_mag_c : rem_mag_c;
  end

`ifdef DIV_SKIP_ZERO_EN
  logic [CW-1:0] lz_c;

  iter_div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .val_i     (dvd_mag_c),
    .count_c_o (lz_c)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      dbz_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= '{op_rem: bus.op_rem, op_signed: bus.op_signed};
            dvd_neg_q  <= dvd_neg_c;
            dvs_neg_q  <= dvs_neg_c;
            dvs_q      <= dvs_mag_c;
            rem_q      <= '0;
            cnt_q      <= CW'(WIDTH - 1);
            in_ready_q <= 1'b0;
            dbz_q      <= 1'b0;
            if (bus.divisor == '0) begin
              quo_q       <= dvd_mag_c;
              result_q    <= bus.op_rem ? bus.dividend : '1;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
`ifdef DIV_SKIP_ZERO_EN
              quo_q   <= dvd_mag_c << lz_c;
              cnt_q   <= CW'(WIDTH - 1) - lz_c;
              state_q <= (dvd_mag_c == '0) ? FIX : CALC;
`else
              quo_q   <= dvd_mag_c;
              state_q <= CALC;
`endif
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[WIDTH-2:0], ~rem_d[WIDTH]};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          result_q    <= op_q.op_rem ? rem_res_c : quo_res_c;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/iter_div.md
Name: iter_div

Overview:
- Sequential radix-2 non-restoring integer divider for the execute stage.
- Serves DIV.W, DIV.WU, MOD.W and MOD.WU.
- Companion to the Booth multiply path: the multiply unit builds products from recoded partial sums; this block undoes that operation one quotient bit per cycle.
- Sits beside the multiplier in the EXU, behind a valid/ready handshake, with a flush input from the pipeline.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  abort the current operation; takes priority over everything else.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block is idle and can accept a request.
- op_signed  in  1  1 = signed (DIV.W/MOD.W), 0 = unsigned.
- op_rem  in  1  1 = return remainder, 0 = return quotient.
- dividend  in  WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  quotient or remainder.
- div_by_zero  out  1  qualifies result: divisor was zero.

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, result=0, div_by_zero=0.
  - State is IDLE; internal registers are cleared.
- States and transitions:
  - IDLE: in_ready=1. On in_valid:
    - Latch op_signed, op_rem, the operand signs, |dividend| and |divisor| (magnitudes only when op_signed; raw values otherwise).
    - Set cnt=WIDTH-1.
    - If divisor==0, go to DONE directly: quotient = all ones, remainder = dividend (unmodified), div_by_zero=1. Latency 1 cycle.
    - Otherwise go to CALC.
  - CALC: one non-restoring step per cycle on a (WIDTH+1)-bit partial remainder.
    - Add or subtract the divisor depending on the sign of the partial remainder.
    - Shift in one quotient bit.
    - cnt decrements; when cnt==0, go to FIX.
  - FIX (1 cycle):
    - If the partial remainder is negative, add the divisor back.
    - Apply signs: quotient negated iff the operand signs differ; remainder takes the dividend's sign.
    - Select quotient or remainder into result and go to DONE.
  - DONE: out_valid=1 with result held stable. When out_ready=1, go to IDLE that cycle.
- Handshake rules:
  - Back-to-back: a new request can be accepted the cycle after the DONE handshake, not in the same cycle.
  - Nominal latency from the accept edge to out_valid is WIDTH+2 cycles (34 for the default width).
  - Result must stay stable while out_valid && !out_ready.
- Signed overflow: INT_MIN / -1 gives quotient INT_MIN (0x80000000) and remainder 0. No trap; the wrap falls out of the magnitude arithmetic.
- Unsigned divisor 0xFFFFFFFF is handled by the WIDTH+1-bit remainder.
- Flush:
  - In any state, the next state is IDLE and out_valid drops the next cycle.
  - flush concurrent with in_valid in IDLE: the request is not accepted.
  - flush concurrent with the DONE handshake: treated as a flush; the result is considered dropped.
- in_valid must not be asserted with X operands; the bench checks this only by assertion.

Optional Feature:
- Macro DIV_SKIP_ZERO_EN, defined:
  - In IDLE, compute lz = leading-zero count of the dividend magnitude.
  - Pre-shift the dividend by lz, set cnt=WIDTH-1-lz, and go straight to CALC.
  - Dividend 0 skips to FIX with quotient 0, remainder 0.
  - Latency becomes WIDTH-lz+2; results are identical to the non-skip build.
- Macro undefined: the fixed WIDTH-step sequence.

Decomposition:
- Shared exu package:
  - state enum {IDLE, CALC, FIX, DONE}.
  - Localparam DIV_LAT = WIDTH+2.
  - The op encoding constants (signed/rem bits) shared with the decoder.
- One sub-module, div_lzc: parameterised leading-zero counter. Instantiated only under DIV_SKIP_ZERO_EN.

Test Plan:
- Unsigned: 100 / 7, op_rem=0 then 1 → 14, then 2; out_valid exactly 34 cycles after accept (non-skip build).
- Signed: -7 / 2 → quotient -3 (0xFFFFFFFD); remainder -1 (0xFFFFFFFF). 7 / -2 → -3, remainder 1.
- Divide by zero: 0x12345678 / 0, signed and unsigned → quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero=1; out_valid the cycle after accept.
- Overflow: 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0. Unsigned → quotient 0, remainder 0x80000000.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles → result stable and in_ready=0 throughout.
  - Assert flush mid-CALC → in_ready=1 next cycle, no out_valid.
  - A new request then gives the correct result.
- Reset mid-CALC (rst_n low asynchronously) → out_valid=0 and in_ready=1 immediately. Then 10000 random signed/unsigned ops checked against a reference model, in both the skip and non-skip builds.
